// File: rtl/frame_sequencer.sv
// frame_sequencer: double-buffered channel frame store; i_wen/i_waddr/i_wdata fill the load bank, i_commit/i_time queue it, i_drq ticks elapsed time and swaps in the pending frame, i_raddr/o_rdata read the active bank, o_ready/o_valid/o_swap/o_overrun/o_target_time/o_elapsed report status
module frame_sequencer #(
  parameter int c_ledboards = 30,
  parameter int c_bpc = 12,
  parameter int c_max_time = 480,
  localparam int c_channels = c_ledboards * 32,
  localparam int c_addr_w = $clog2(c_channels),
  localparam int c_time_w = $clog2(c_max_time + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wen,
  input  logic [c_addr_w-1:0] i_waddr,
  input  logic [c_bpc-1:0]    i_wdata,
  input  logic                i_commit,
  input  logic [c_time_w-1:0] i_time,
  input  logic                i_drq,
  input  logic [c_addr_w-1:0] i_raddr,
  output logic [c_bpc-1:0]    o_rdata,
  output logic [c_time_w-1:0] o_target_time,
  output logic [c_time_w-1:0] o_elapsed,
  output logic                o_ready,
  output logic                o_valid,
  output logic                o_swap,
  output logic                o_overrun
);
  localparam logic [c_addr_w-1:0] c_last = c_addr_w'(c_channels - 1);
  localparam logic [c_time_w-1:0] c_tmax = c_time_w'(c_max_time);
  logic [c_bpc-1:0] mem [2][c_channels];
  logic [c_time_w-1:0] load_dur;
  logic active, pending, do_swap, commit_ok;
  assign o_ready = ~pending;
  assign do_swap = i_drq && pending && o_elapsed >= o_target_time;
  assign commit_ok = i_commit && !pending;
  always_ff @(posedge i_clk)
    if (i_wen && !pending && i_waddr <= c_last) mem[~active][i_waddr] <= i_wdata;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      active <= 1'b0;
      pending <= 1'b0;
      load_dur <= '0;
      o_valid <= 1'b0;
      o_target_time <= '0;
      o_elapsed <= '0;
      o_rdata <= '0;
      o_swap <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_swap <= do_swap;
      o_overrun <= i_commit && pending;
      o_rdata <= (o_valid && i_raddr <= c_last) ? mem[active][i_raddr] : '0;
      if (do_swap) begin
        active <= ~active;
        o_target_time <= load_dur;
        o_elapsed <= '0;
        pending <= 1'b0;
        o_valid <= 1'b1;
      end else if (i_drq && o_elapsed < o_target_time) begin
        o_elapsed <= o_elapsed + 1'b1;
      end
      if (commit_ok) begin
        pending <= 1'b1;
        load_dur <= (i_time > c_tmax) ? c_tmax : i_time;
      end
    end
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scenario tasks with a read-data scoreboard queue for frame_sequencer
module tb_frame_sequencer;
  logic i_clk, i_rst, i_wen, i_commit, i_drq;
  logic [9:0] i_waddr, i_raddr;
  logic [11:0] i_wdata;
  logic [8:0] i_time;
  logic [11:0] o_rdata;
  logic [8:0] o_target_time, o_elapsed;
  logic o_ready, o_valid, o_swap, o_overrun;
  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_q [$];
  logic [11:0] e;

  frame_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .i_commit(i_commit), .i_time(i_time), .i_drq(i_drq), .i_raddr(i_raddr),
    .o_rdata(o_rdata), .o_target_time(o_target_time), .o_elapsed(o_elapsed),
    .o_ready(o_ready), .o_valid(o_valid), .o_swap(o_swap), .o_overrun(o_overrun)
  );

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    i_wen = 1; i_waddr = 10'(a); i_wdata = 12'(d);
    cyc();
    i_wen = 0;
  endtask

  task automatic commit(input int t);
    i_commit = 1; i_time = 9'(t);
    cyc();
    i_commit = 0;
  endtask

  task automatic drq();
    i_drq = 1;
    cyc();
    i_drq = 0;
  endtask

  task automatic rd_issue(input int a, input int x);
    i_raddr = 10'(a);
    exp_q.push_back(12'(x));
    cyc();
  endtask

  task automatic test_reset();
    i_rst = 1; i_wen = 0; i_commit = 0; i_drq = 0;
    i_waddr = 0; i_wdata = 0; i_time = 0; i_raddr = 0;
    repeat (2) cyc();
    i_rst = 0;
    cyc();
    vectors++;
    if ({o_ready, o_valid, o_swap, o_overrun} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 1000", {o_ready, o_valid, o_swap, o_overrun});
    end
    vectors++;
    if ({o_target_time, o_elapsed, o_rdata} !== 30'd0) begin
      miscompares++;
      $display("FAIL reset_values: got tt=%0d el=%0d rd=%0h expected 0", o_target_time, o_elapsed, o_rdata);
    end
  endtask

  task automatic test_first_frame();
    wr(5, 'hABC);
    commit(4);
    vectors++;
    if (o_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_ready: got %b expected 0", o_ready);
    end
    drq();
    vectors++;
    if ({o_swap, o_valid, o_ready, o_target_time, o_elapsed} !== {3'b111, 9'd4, 9'd0}) begin
      miscompares++;
      $display("FAIL first_swap: got sw=%b v=%b r=%b tt=%0d el=%0d expected 1 1 1 4 0",
               o_swap, o_valid, o_ready, o_target_time, o_elapsed);
    end
    rd_issue(5, 'hABC);
    vectors++;
    if (o_swap !== 1'b0) begin
      miscompares++;
      $display("FAIL swap_pulse: got %b expected 0", o_swap);
    end
    e = exp_q.pop_front();
    vectors++;
    if (o_rdata !== e) begin
      miscompares++;
      $display("FAIL first_read: got %0h expected %0h", o_rdata, e);
    end
  endtask

  task automatic test_elapsed();
    wr(7, 'h123);
    commit(2);
    for (int k = 1; k <= 4; k++) begin
      drq();
      vectors++;
      if (o_elapsed !== 9'(k) || o_swap !== 1'b0) begin
        miscompares++;
        $display("FAIL elapsed_%0d: got el=%0d sw=%b expected %0d 0", k, o_elapsed, o_swap, k);
      end
    end
    drq();
    vectors++;
    if ({o_swap, o_elapsed, o_target_time} !== {1'b1, 9'd0, 9'd2}) begin
      miscompares++;
      $display("FAIL fifth_drq_swap: got sw=%b el=%0d tt=%0d expected 1 0 2", o_swap, o_elapsed, o_target_time);
    end
    rd_issue(7, 'h123);
    e = exp_q.pop_front();
    vectors++;
    if (o_rdata !== e) begin
      miscompares++;
      $display("FAIL elapsed_read: got %0h expected %0h", o_rdata, e);
    end
  endtask

  task automatic test_overrun();
    wr(9, 'h0F0);
    commit(3);
    wr(9, 'h555);
    commit(7);
    vectors++;
    if (o_overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_pulse: got %b expected 1", o_overrun);
    end
    cyc();
    vectors++;
    if (o_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_width: got %b expected 0", o_overrun);
    end
    repeat (2) drq();
    drq();
    vectors++;
    if (o_swap !== 1'b1 || o_target_time !== 9'd3) begin
      miscompares++;
      $display("FAIL overrun_duration: got sw=%b tt=%0d expected 1 3", o_swap, o_target_time);
    end
    rd_issue(9, 'h0F0);
    e = exp_q.pop_front();
    vectors++;
    if (o_rdata !== e) begin
      miscompares++;
      $display("FAIL blocked_write: got %0h expected %0h", o_rdata, e);
    end
    rd_issue(1000, 0);
    e = exp_q.pop_front();
    vectors++;
    if (o_rdata !== e) begin
      miscompares++;
      $display("FAIL oob_read: got %0h expected %0h", o_rdata, e);
    end
  endtask

  task automatic test_saturate();
    for (int k = 1; k <= 5; k++) begin
      drq();
      vectors++;
      if (o_elapsed !== 9'(k > 3 ? 3 : k) || o_swap !== 1'b0) begin
        miscompares++;
        $display("FAIL saturate_%0d: got el=%0d sw=%b expected %0d 0", k, o_elapsed, o_swap, k > 3 ? 3 : k);
      end
    end
  endtask

  task automatic test_clamp();
    // 1000 does not fit the 9-bit i_time port; 511 is the largest over-range value
    commit(511);
    drq();
    vectors++;
    if (o_swap !== 1'b1 || o_target_time !== 9'd480) begin
      miscompares++;
      $display("FAIL clamp: got sw=%b tt=%0d expected 1 480", o_swap, o_target_time);
    end
  endtask

  task automatic test_back_to_back();
    int swaps;
    i_commit = 1; i_time = 0; i_drq = 1;
    cyc();
    i_commit = 0; i_drq = 0;
    vectors++;
    if ({o_swap, o_ready, o_elapsed} !== {2'b00, 9'd1}) begin
      miscompares++;
      $display("FAIL commit_drq: got sw=%b r=%b el=%0d expected 0 0 1", o_swap, o_ready, o_elapsed);
    end
    swaps = 0;
    for (int k = 0; k < 479; k++) begin
      drq();
      swaps += int'(o_swap);
    end
    vectors++;
    if (swaps != 0 || o_elapsed !== 9'd480) begin
      miscompares++;
      $display("FAIL long_run: got swaps=%0d el=%0d expected 0 480", swaps, o_elapsed);
    end
    i_commit = 1; i_time = 5; i_drq = 1;
    cyc();
    i_commit = 0; i_drq = 0;
    vectors++;
    if ({o_swap, o_overrun, o_ready, o_target_time} !== {3'b111, 9'd0}) begin
      miscompares++;
      $display("FAIL swap_commit: got sw=%b ov=%b r=%b tt=%0d expected 1 1 1 0",
               o_swap, o_overrun, o_ready, o_target_time);
    end
    commit(2);
    drq();
    vectors++;
    if (o_swap !== 1'b1 || o_target_time !== 9'd2) begin
      miscompares++;
      $display("FAIL zero_duration: got sw=%b tt=%0d expected 1 2", o_swap, o_target_time);
    end
  endtask

  task automatic test_async_reset();
    rd_issue(7, 'h123);
    e = exp_q.pop_front();
    vectors++;
    if (o_rdata !== e) begin
      miscompares++;
      $display("FAIL pre_reset_read: got %0h expected %0h", o_rdata, e);
    end
    commit(4);
    #3;
    i_rst = 1;
    #1;
    vectors++;
    if ({o_valid, o_ready, o_swap, o_overrun, o_rdata, o_target_time, o_elapsed} !== {4'b0100, 30'd0}) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b r=%b rd=%0h tt=%0d el=%0d expected 0 1 0 0 0",
               o_valid, o_ready, o_rdata, o_target_time, o_elapsed);
    end
    cyc();
    i_rst = 0;
    cyc();
    drq();
    vectors++;
    if ({o_swap, o_valid, o_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL pending_discarded: got sw=%b v=%b r=%b expected 0 0 1", o_swap, o_valid, o_ready);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_elapsed();
    test_overrun();
    test_saturate();
    test_clamp();
    test_back_to_back();
    test_async_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
